// File: rtl/adder_pkg.sv
// Shared constants and types for the shared-adder scheduling slice.
package adder_pkg;

  localparam int unsigned ADD_W       = 16;
  localparam int unsigned NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
  } slot_state_e;

endpackage

// File: rtl/BigAdder.sv
// Shared 16-bit ripple-carry adder; c_out exposes every stage carry, So the sum.
module BigAdder
  import adder_pkg::*;
(
  input  logic [ADD_W-1:0] a_in,
  input  logic [ADD_W-1:0] b_in,
  output logic [ADD_W-1:0] c_out,
  output logic [ADD_W-1:0] So
);

  always_comb begin : p_ripple
    logic cy;
    cy    = 1'b0;
    c_out = '0;
    So    = '0;
    for (int unsigned i = 0; i < ADD_W; i++) begin
      So[i]    = a_in[i] ^ b_in[i] ^ cy;
      cy       = (a_in[i] & b_in[i]) | (cy & (a_in[i] ^ b_in[i]));
      c_out[i] = cy;
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one BigAdder among NUM_REQ requesters,
// with a single result slot that can drain and reload in the same cycle.
module adder_sched
  import adder_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned W       = ADD_W,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  slot_state_e        r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [W-1:0]       r_sum;
  logic               r_cout;

  logic               w_any;
  logic               w_can_load;
  logic               w_accept;
  logic [IDW-1:0]     w_gnt;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0] w_ready;
  logic [W-1:0]       w_a;
  logic [W-1:0]       w_b;
  logic [W-1:0]       w_so;
  logic               w_cout;
  logic [W-2:0]       w_carry_unused;

  // First valid requester scanning upward from ptr, wrapping; MSB = found.
  function automatic logic [IDW:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
    logic           found;
    logic [IDW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((32'(ptr) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {w_any, w_gnt} = f_rr_pick(req_valid, r_rr_ptr);
    w_can_load     = (r_state == EMPTY) || rsp_ready;
    w_ready        = '0;
    // No grant may escape while reset is held, even though the slot reads EMPTY.
    if (rst_n && w_can_load && w_any) begin
      w_ready[w_gnt] = 1'b1;
    end
    w_accept = |w_ready;
    w_a      = '0;
    w_b      = '0;
    if (w_accept) begin
      w_a = req_a[w_gnt*W +: W];
      w_b = req_b[w_gnt*W +: W];
    end
    w_ptr_nxt = (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + IDW'(1);
  end

  BigAdder u_add (
    .a_in  (w_a),
    .b_in  (w_b),
    .c_out ({w_cout, w_carry_unused}),
    .So    (w_so)
  );

  // Result slot: accept overrides drain so a reload keeps rsp_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_state  <= FULL;
      r_rr_ptr <= w_ptr_nxt;
      r_id     <= w_gnt;
      r_sum    <= w_so;
      r_cout   <= w_cout;
    end else if ((r_state == FULL) && rsp_ready) begin
      r_state  <= EMPTY;
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = rst_n && (rsp_valid || (|req_valid));

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: round-robin/slot reference model with a result scoreboard.
module tb_adder_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]    req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_sum;
  logic             rsp_cout;
  logic             busy;

  adder_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the slot and round-robin pointer, evaluated before each edge
  exp_t          sbq[$];
  logic          m_full = 1'b0;
  int            m_ptr  = 0;
  logic [NR-1:0] m_acc  = '0;
  int            n_acc  = 0;
  int            n_rsp  = 0;

  always @(negedge clk) begin
    logic          ok;
    int            g;
    logic [1:0]    idx;
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_acc  = '0;
      sbq.delete();
    end else begin
      ok = 1'b0;
      g  = 0;
      for (int k = 0; k < NR; k++) begin
        idx = 2'((m_ptr + k) % NR);
        if (!ok && req_valid[idx]) begin
          ok = 1'b1;
          g  = int'(idx);
        end
      end
      exp_rdy = ((!m_full || rsp_ready) && ok) ? NR'(1 << g) : '0;
      chk_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk_eq("busy", 32'(busy), 32'(m_full || (|req_valid)));
      if (m_full && rsp_ready) begin
        n_rsp++;
        if (sbq.size() == 0) begin
          chk_eq("sb_depth", 32'(sbq.size()), 32'(1));
        end else begin
          e = sbq.pop_front();
          chk_eq("sb_id", 32'(rsp_id), 32'(e.id));
          chk_eq("sb_sum", 32'(rsp_sum), 32'(e.sum));
          chk_eq("sb_cout", 32'(rsp_cout), 32'(e.cout));
        end
      end
      if (exp_rdy != '0) begin
        e.id = 2'(g);
        {e.cout, e.sum} = 17'(req_a[g*DW +: DW]) + 17'(req_b[g*DW +: DW]);
        sbq.push_back(e);
        n_acc++;
        m_full = 1'b1;
        m_ptr  = (g + 1) % NR;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
      m_acc = exp_rdy;
    end
  end

  // Stimulus: per-requester operand sources, valid held until the model sees acceptance
  logic [31:0] src[NR][$];
  int unsigned vprob  = 100;
  bit          soak   = 1'b0;
  int          n_sent = 0;
  logic        t_rv, t_fire, t_cout;
  logic [1:0]  t_id;
  logic [15:0] t_sum;
  logic [3:0]  t_rdy;

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
    src[i].push_back({a, b});
    n_sent++;
  endtask

  task automatic tick();
    @(negedge clk);
    t_rv   = rsp_valid;
    t_fire = rsp_valid && rsp_ready;
    t_id   = rsp_id;
    t_sum  = rsp_sum;
    t_cout = rsp_cout;
    t_rdy  = req_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      req_valid = '0;
      for (int i = 0; i < NR; i++) src[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && m_acc[i]) begin
          void'(src[i].pop_front());
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && src[i].size() != 0 && $urandom_range(99) < vprob) begin
          req_a[i*DW +: DW] = src[i][0][31:16];
          req_b[i*DW +: DW] = src[i][0][15:0];
          req_valid[i]      = 1'b1;
        end
      end
      if (soak) rsp_ready = ($urandom_range(99) < 70);
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] id, input logic [15:0] sum,
                          input logic cout, output int cyc);
    cyc = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      cyc++;
      if (t_fire) begin
        chk_eq({tag, "_id"}, 32'(t_id), 32'(id));
        chk_eq({tag, "_sum"}, 32'(t_sum), 32'(sum));
        chk_eq({tag, "_cout"}, 32'(t_cout), 32'(cout));
        return;
      end
    end
    chk_eq({tag, "_seen"}, 32'(t_fire), 32'(1));
  endtask

  int cyc, acc0, rsp0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk_eq("rst_rsp_sum", 32'(rsp_sum), 32'(0));
    chk_eq("rst_req_ready", 32'(req_ready), 32'(0));
    rst_n = 1'b1;

    // All four valid together: grants 0,1,2,3
    send(0, 16'h1E3B, 16'h2024);
    send(1, 16'h2AFB, 16'h0144);
    send(2, 16'h1234, 16'h8765);
    send(3, 16'hFFFF, 16'h0001);
    wait_rsp("t3_g0", 2'd0, 16'h3E5F, 1'b0, cyc);
    wait_rsp("t3_g1", 2'd1, 16'h2C3F, 1'b0, cyc);
    wait_rsp("t3_g2", 2'd2, 16'h9999, 1'b0, cyc);
    wait_rsp("t3_g3", 2'd3, 16'h0000, 1'b1, cyc);

    // Single requester, back-to-back
    send(2, 16'hF0F0, 16'h0F0F);
    send(2, 16'hE2A1, 16'h1234);
    wait_rsp("t2_r0", 2'd2, 16'hFFFF, 1'b0, cyc);
    wait_rsp("t2_r1", 2'd2, 16'hF4D5, 1'b0, cyc);
    chk_eq("t2_gap", 32'(cyc), 32'(1));

    // Pointer sits at 3: scan wraps to requester 0, then 1
    send(0, 16'h8000, 16'h8000);
    send(1, 16'h7FFF, 16'h0001);
    wait_rsp("t5_r0", 2'd0, 16'h0000, 1'b1, cyc);
    wait_rsp("t5_r1", 2'd1, 16'h8000, 1'b0, cyc);
    repeat (2) tick();

    // Backpressure: pointer at 2, so requester 3 fills the slot and stalls
    rsp_ready = 1'b0;
    send(3, 16'h1111, 16'h2222);
    send(0, 16'h0F00, 16'h00F0);
    send(1, 16'h4000, 16'h4000);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (t_rv) break;
    end
    for (int k = 0; k < 5; k++) begin
      chk_eq("t4_hold_valid", 32'(t_rv), 32'(1));
      chk_eq("t4_hold_id", 32'(t_id), 32'(3));
      chk_eq("t4_hold_sum", 32'(t_sum), 32'h3333);
      chk_eq("t4_hold_ready", 32'(t_rdy), 32'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk_eq("t4_drain", 32'(t_fire), 32'(1));
    chk_eq("t4_drain_id", 32'(t_id), 32'(3));
    chk_eq("t4_reload", 32'(t_rdy), 32'b0001);
    wait_rsp("t4_r0", 2'd0, 16'h0FF0, 1'b0, cyc);
    chk_eq("t4_nobubble0", 32'(cyc), 32'(1));
    wait_rsp("t4_r1", 2'd1, 16'h8000, 1'b0, cyc);
    chk_eq("t4_nobubble1", 32'(cyc), 32'(1));
    repeat (2) tick();

    // Reset mid-stall with a pending requester
    rsp_ready = 1'b0;
    send(1, 16'hABCD, 16'h1000);
    send(2, 16'h1234, 16'h1111);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (t_rv) break;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("t1_rsp_valid", 32'(rsp_valid), 32'(0));
    chk_eq("t1_req_ready", 32'(req_ready), 32'(0));
    chk_eq("t1_rsp_sum", 32'(rsp_sum), 32'(0));
    chk_eq("t1_rsp_cout", 32'(rsp_cout), 32'(0));
    chk_eq("t1_rsp_id", 32'(rsp_id), 32'(0));
    chk_eq("t1_busy", 32'(busy), 32'(0));
    repeat (2) tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    send(0, 16'h0001, 16'h0002);
    send(1, 16'h0010, 16'h0020);
    send(2, 16'h0100, 16'h0200);
    send(3, 16'h1000, 16'h2000);
    wait_rsp("t1_first", 2'd0, 16'h0003, 1'b0, cyc);
    repeat (8) tick();

    // Random soak against the model and scoreboard
    acc0  = n_acc;
    rsp0  = n_rsp;
    vprob = 60;
    soak  = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] a, b;
      a = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      send(k % NR, a, b);
    end
    for (int n = 0; n < 30000; n++) begin
      tick();
      if (src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 &&
          src[3].size() == 0 && req_valid == '0 && sbq.size() == 0 && !t_rv) break;
    end
    soak = 1'b0;
    chk_eq("soak_accepts", 32'(n_acc - acc0), 32'(2000));
    chk_eq("soak_responses", 32'(n_rsp - rsp0), 32'(2000));
    chk_eq("soak_sb_left", 32'(sbq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares one 16-bit `BigAdder` datapath among `NUM_REQ` requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle and drives the adder with that requester's operands.
- It captures sum and carry-out in a single output register, tagged with the requester id, and holds the result until the consumer accepts it.
- It sits between the operand producers and the shared adder and is the only instantiator of `BigAdder`.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `W`, default 16: operand width. Fixed to 16 to match `BigAdder`.
- `IDW`, default 2: id width, equal to $clog2(NUM_REQ).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has an operand pair pending.
- `req_a` in NUM_REQ*W: operand A, requester i at bits [i*W +: W].
- `req_b` in NUM_REQ*W: operand B, same packing as `req_a`.
- `req_ready` out NUM_REQ: one-hot grant; requester i's pair is accepted this cycle.
- `rsp_valid` out 1: result register holds a valid result.
- `rsp_ready` in 1: consumer accepts the result this cycle.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_sum` out W: `BigAdder` So.
- `rsp_cout` out 1: `BigAdder` c_out[W-1], the final carry.
- `busy` out 1: high whenever `rsp_valid` is high or any `req_valid` bit is high.

## Operation

- State is two bits: `EMPTY` (no result held) and `FULL` (result held).
  - `EMPTY`: the slot can load.
  - `FULL` with `rsp_ready`=1: the slot drains and reloads in the same cycle, giving throughput of 1 per cycle.
  - `FULL` with `rsp_ready`=0: stall. `req_ready` is all zero.
- `can_load` = (state==EMPTY) OR `rsp_ready`.
- Arbitration (combinational):
  - Pick the first requester with valid=1, scanning upward from pointer `rr_ptr` and wrapping modulo `NUM_REQ`.
  - `req_ready` = onehot(grant) when `can_load` is high and at least one request is valid; otherwise all zero.
  - `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Adder drive: the mux selects the granted requester's A and B into `BigAdder`. When nothing is granted, the mux drives zeros.
- On accept (a one-hot `req_ready` bit with its valid):
  - Register the sum, c_out[W-1], and the grant index.
  - Set state to `FULL`.
  - Set `rr_ptr` to (grant+1) mod NUM_REQ.
- On drain with no accept: state goes to `EMPTY`. `rsp_*` data hold their last values; the consumer ignores them.
- `rr_ptr` does not move in cycles with no grant.
- Arithmetic: modulo 2^16. `rsp_cout` is the 17th bit. No saturation. Operands are unsigned.
- Requester i must hold its A and B stable while `req_valid[i]` is high and the pair is not yet accepted.

## Timing

- Reset (`rst_n`=0, asynchronous, at any time including mid-stall):
  - State = `EMPTY`, `rr_ptr` = 0.
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `busy`=0.
  - `req_ready`=0 while reset is asserted.
  - A held result is discarded. No response is generated for it.
- Latency: a request accepted at edge N appears with `rsp_valid`=1 after edge N, and stays there until the edge where `rsp_ready`=1.
- Simultaneous drain and accept: the new result replaces the old one with no bubble, and `rsp_valid` stays high.
- Fairness: with every requester continuously valid and `rsp_ready`=1, grants rotate 0,1,...,NUM_REQ-1,0. Each requester gets one grant in every NUM_REQ consecutive accepts.
- Wrap-around: with `rr_ptr`=NUM_REQ-1 and only requester 0 valid, requester 0 is granted and `rr_ptr` becomes 1.

## Structure

- The shared package `adder_pkg` holds:
  - `ADD_W`=16.
  - The default `NUM_REQ`.
  - The state enum {EMPTY, FULL}.
- Sub-module: the existing `BigAdder` (a_in, b_in, c_out, So), instantiated once as `u_add`.
- Keep the arbiter as a local function or always block. Do not create a separate module for it.

## Test plan

1. Reset: pulse `rst_n` low mid-stall, with `rsp_valid`=1 and `rsp_ready`=0.
   - Required: `rsp_valid`=0, `req_ready`=0, `rsp_sum`=0 immediately.
   - Required: after release, the first grant goes to requester 0.
2. Single requester, `rsp_ready`=1: requester 2 sends F0F0+0F0F, then E2A1+1234.
   - Required: results FFFF/cout0/id2, then F4D5/cout0/id2, on consecutive cycles.
3. All four requesters valid with 1E3B+2024, 2AFB+0144, 1234+8765 and FFFF+0001 on ids 0..3.
   - Required: grants in order 0,1,2,3.
   - Required results: 3E5F/0, 2C3F/0, 9999/0, 0000/cout1.
4. Backpressure: hold `rsp_ready`=0 for 5 cycles with results pending.
   - Required: `rsp_*` stable and `req_ready`=0 throughout.
   - Required: when `rsp_ready` rises, the drain and the next accept happen in the same cycle.
5. Wrap: grant requester 3, then only requester 0 and requester 1 valid.
   - Required: requester 0 is granted next, then requester 1.
6. Random soak (≥2000 cycles) against a reference model:
   - Sum and cout correct.
   - No lost or duplicated requests.
   - Per-requester order preserved.
